// File: rtl/phy_mgmt_pkg.sv
// Shared definitions for the PHY management controller: MII register map,
// bit positions, fixed register values, FSM state types and link-mode decoding.
package phy_mgmt_pkg;

    localparam logic [4:0] BMCR_ADDR   = 5'd0;
    localparam logic [4:0] BMSR_ADDR   = 5'd1;
    localparam logic [4:0] ANAR_ADDR   = 5'd4;
    localparam logic [4:0] ANLPAR_ADDR = 5'd5;

    localparam int BMCR_RESET_BIT     = 15;
    localparam int BMSR_LINK_BIT      = 2;
    localparam int BMSR_ANEG_DONE_BIT = 5;
    localparam int LPA_100FD_BIT      = 8;
    localparam int LPA_100HD_BIT      = 7;
    localparam int LPA_10FD_BIT       = 6;

    localparam logic [15:0] BMCR_RESET_VAL = 16'h8000;
    localparam logic [15:0] ANAR_ADV_VAL   = 16'h01E1;
    localparam logic [15:0] BMCR_ANEG_VAL  = 16'h1200;

    typedef enum logic [3:0] {
        IDLE,
        RST_WR,
        RST_POLL,
        ANAR_WR,
        AN_WR,
        LINK_POLL,
        LPA_RD,
        MONITOR,
        GAP,
        FAULT
    } state_t;

    typedef enum logic [1:0] {
        TXN_IDLE,
        TXN_ASSERT,
        TXN_WAIT
    } txn_state_t;

    typedef struct packed {
        logic speed100;
        logic fullDuplex;
    } link_mode_t;

    // Highest common ability wins, in 100FD > 100HD > 10FD > 10HD order.
    function automatic link_mode_t resolveLinkMode(input logic [15:0] lpa);
        logic [15:0] common;
        link_mode_t  mode;
        common = lpa & ANAR_ADV_VAL;
        mode   = '0;
        if (common[LPA_100FD_BIT]) begin
            mode.speed100   = 1'b1;
            mode.fullDuplex = 1'b1;
        end else if (common[LPA_100HD_BIT]) begin
            mode.speed100 = 1'b1;
        end else if (common[LPA_10FD_BIT]) begin
            mode.fullDuplex = 1'b1;
        end
        return mode;
    endfunction

endpackage

// File: rtl/phy_mgmt_ctrl_if.sv
// Request/response bus between the management controller and the MDIO serial engine.
interface phy_mgmt_ctrl_if;
    logic        mdio_en;
    logic        mdio_op;
    logic [4:0]  mdio_phyad;
    logic [4:0]  mdio_regad;
    logic [15:0] mdio_wdata;
    logic        mdio_valid;
    logic [15:0] mdio_rdata;

    modport master (
        output mdio_en,
        output mdio_op,
        output mdio_phyad,
        output mdio_regad,
        output mdio_wdata,
        input  mdio_valid,
        input  mdio_rdata
    );

    modport slave (
        input  mdio_en,
        input  mdio_op,
        input  mdio_phyad,
        input  mdio_regad,
        input  mdio_wdata,
        output mdio_valid,
        output mdio_rdata
    );
endinterface

// File: rtl/phy_mgmt_ctrl_mdio_txn.sv
// Runs one request/acknowledge exchange with the serial engine and flags a
// timeout when the engine does not finish in time.
module mdio_txn
    import phy_mgmt_pkg::*;
#(
    parameter logic [4:0]  PHYAD       = 5'd1,
    parameter logic [31:0] TXN_TIMEOUT = 32'd100_000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_i,
    input  logic                   op_i,
    input  logic [4:0]             regad_i,
    input  logic [15:0]            wdata_i,
    output logic                   done_o,
    output logic [15:0]            rdata_o,
    output logic                   timeout_o,
    phy_mgmt_ctrl_if.master        mdio
);

    txn_state_t  state_q, state_d;
    logic        en_q, en_d;
    logic        op_q, op_d;
    logic [4:0]  phyad_q, phyad_d;
    logic [4:0]  regad_q, regad_d;
    logic [15:0] wdata_q, wdata_d;
    logic [31:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= TXN_IDLE;
            en_q    <= 1'b0;
            op_q    <= 1'b0;
            phyad_q <= '0;
            regad_q <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            op_q    <= op_d;
            phyad_q <= phyad_d;
            regad_q <= regad_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request fields are latched once at launch so the bus stays stable until completion.
    always_comb begin
        state_d = state_q;
        en_d    = en_q;
        op_d    = op_q;
        phyad_d = phyad_q;
        regad_d = regad_q;
        wdata_d = wdata_q;
        cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + 32'd1;
        unique case (state_q)
            TXN_IDLE: begin
                cnt_d = '0;
                if (req_i) begin
                    state_d = TXN_ASSERT;
                    en_d    = 1'b1;
                    op_d    = op_i;
                    phyad_d = PHYAD;
                    regad_d = regad_i;
                    wdata_d = wdata_i;
                end
            end
            TXN_ASSERT: begin
                if (timeout_o) begin
                    state_d = TXN_IDLE;
                    en_d    = 1'b0;
                end else if (!mdio.mdio_valid) begin
                    state_d = TXN_WAIT;
                    en_d    = 1'b0;
                end
            end
            TXN_WAIT: begin
                if (done_o || timeout_o) begin
                    state_d = TXN_IDLE;
                end
            end
            default: begin
                state_d = TXN_IDLE;
                en_d    = 1'b0;
            end
        endcase
    end

    always_comb begin
        done_o    = (state_q == TXN_WAIT) && mdio.mdio_valid;
        timeout_o = (state_q != TXN_IDLE) && !done_o &&
                    (({1'b0, cnt_q} + 33'd1) >= {1'b0, TXN_TIMEOUT});
    end

    assign rdata_o         = mdio.mdio_rdata;
    assign mdio.mdio_en    = en_q;
    assign mdio.mdio_op    = op_q;
    assign mdio.mdio_phyad = phyad_q;
    assign mdio.mdio_regad = regad_q;
    assign mdio.mdio_wdata = wdata_q;

endmodule

// File: rtl/phy_mgmt_ctrl.sv
// PHY bring-up sequencer: soft reset, advertise, autonegotiate, resolve the
// link mode and keep polling link status afterwards.
module phy_mgmt_ctrl
    import phy_mgmt_pkg::*;
#(
    parameter logic [4:0]  PHYAD       = 5'd1,
    parameter logic [31:0] POLL_GAP    = 32'd1_000_000,
    parameter logic [31:0] TXN_TIMEOUT = 32'd100_000,
    parameter int          RST_POLLS   = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    phy_mgmt_ctrl_if.master mdio,
    output logic            busy_o,
    output logic            link_up_o,
    output logic            speed_100_o,
    output logic            full_duplex_o,
    output logic            error_o
);

    state_t      state_q, state_d;
    state_t      retState_q, retState_d;
    logic [31:0] gapCnt_q, gapCnt_d;
    logic [31:0] pollCnt_q, pollCnt_d;
    logic        linkUp_q, linkUp_d;
    logic        speed100_q, speed100_d;
    logic        fullDuplex_q, fullDuplex_d;
    logic        restartGap;
    logic        gapDone;

    logic        txnReq;
    logic        txnOp;
    logic [4:0]  txnRegad;
    logic [15:0] txnWdata;
    logic        txnDone;
    logic [15:0] txnRdata;
    logic        txnTimeout;
    link_mode_t  lpaMode;

    mdio_txn #(
        .PHYAD       (PHYAD),
        .TXN_TIMEOUT (TXN_TIMEOUT)
    ) u_txn (
        .clk       (clk),
        .rst       (rst),
        .req_i     (txnReq),
        .op_i      (txnOp),
        .regad_i   (txnRegad),
        .wdata_i   (txnWdata),
        .done_o    (txnDone),
        .rdata_o   (txnRdata),
        .timeout_o (txnTimeout),
        .mdio      (mdio)
    );

    assign lpaMode = resolveLinkMode(txnRdata);
    assign gapDone = ({1'b0, gapCnt_q} + 33'd1) >= {1'b0, POLL_GAP};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            retState_q   <= IDLE;
            gapCnt_q     <= '0;
            pollCnt_q    <= '0;
            linkUp_q     <= 1'b0;
            speed100_q   <= 1'b0;
            fullDuplex_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            retState_q   <= retState_d;
            gapCnt_q     <= gapCnt_d;
            pollCnt_q    <= pollCnt_d;
            linkUp_q     <= linkUp_d;
            speed100_q   <= speed100_d;
            fullDuplex_q <= fullDuplex_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        retState_d   = retState_q;
        pollCnt_d    = pollCnt_q;
        linkUp_d     = linkUp_q;
        speed100_d   = speed100_q;
        fullDuplex_d = fullDuplex_q;
        restartGap   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d   = RST_WR;
                    pollCnt_d = '0;
                end
            end
            RST_WR: if (txnDone) state_d = RST_POLL;
            RST_POLL: begin
                if (txnDone) begin
                    if (!txnRdata[BMCR_RESET_BIT]) begin
                        state_d = ANAR_WR;
                    end else if ((pollCnt_q + 32'd1) >= 32'(RST_POLLS)) begin
                        state_d = FAULT;
                    end else begin
                        pollCnt_d  = pollCnt_q + 32'd1;
                        retState_d = RST_POLL;
                        state_d    = GAP;
                    end
                end
            end
            ANAR_WR: if (txnDone) state_d = AN_WR;
            AN_WR:   if (txnDone) state_d = LINK_POLL;
            LINK_POLL: begin
                if (txnDone) begin
                    if (txnRdata[BMSR_LINK_BIT] && txnRdata[BMSR_ANEG_DONE_BIT]) begin
                        state_d = LPA_RD;
                    end else begin
                        retState_d = LINK_POLL;
                        state_d    = GAP;
                    end
                end
            end
            LPA_RD: begin
                if (txnDone) begin
                    speed100_d   = lpaMode.speed100;
                    fullDuplex_d = lpaMode.fullDuplex;
                    linkUp_d     = 1'b1;
                    state_d      = MONITOR;
                end
            end
            // A healthy poll stays here but restarts the inter-poll wait.
            MONITOR: begin
                if (txnDone) begin
                    if (!txnRdata[BMSR_LINK_BIT]) begin
                        linkUp_d     = 1'b0;
                        speed100_d   = 1'b0;
                        fullDuplex_d = 1'b0;
                        state_d      = LINK_POLL;
                    end else begin
                        restartGap = 1'b1;
                    end
                end
            end
            GAP:     if (gapDone) state_d = retState_q;
            FAULT:   state_d = FAULT;
            default: state_d = IDLE;
        endcase
        if (txnTimeout) begin
            state_d = FAULT;
        end
    end

    always_comb begin
        if ((state_d != state_q) || restartGap) begin
            gapCnt_d = '0;
        end else begin
            gapCnt_d = (gapCnt_q == '1) ? gapCnt_q : gapCnt_q + 32'd1;
        end
    end

    always_comb begin
        txnReq   = 1'b0;
        txnOp    = 1'b0;
        txnRegad = BMCR_ADDR;
        txnWdata = '0;
        busy_o   = (state_q != IDLE) && (state_q != FAULT);
        error_o  = (state_q == FAULT);
        unique case (state_q)
            RST_WR: begin
                txnReq   = 1'b1;
                txnOp    = 1'b1;
                txnRegad = BMCR_ADDR;
                txnWdata = BMCR_RESET_VAL;
            end
            RST_POLL: begin
                txnReq   = 1'b1;
                txnRegad = BMCR_ADDR;
            end
            ANAR_WR: begin
                txnReq   = 1'b1;
                txnOp    = 1'b1;
                txnRegad = ANAR_ADDR;
                txnWdata = ANAR_ADV_VAL;
            end
            AN_WR: begin
                txnReq   = 1'b1;
                txnOp    = 1'b1;
                txnRegad = BMCR_ADDR;
                txnWdata = BMCR_ANEG_VAL;
            end
            LINK_POLL: begin
                txnReq   = 1'b1;
                txnRegad = BMSR_ADDR;
            end
            LPA_RD: begin
                txnReq   = 1'b1;
                txnRegad = ANLPAR_ADDR;
            end
            MONITOR: begin
                txnReq   = (gapCnt_q >= POLL_GAP);
                txnRegad = BMSR_ADDR;
            end
            default: txnReq = 1'b0;
        endcase
    end

    assign link_up_o     = linkUp_q;
    assign speed_100_o   = speed100_q;
    assign full_duplex_o = fullDuplex_q;

endmodule

// File: tb/tb_phy_mgmt_ctrl.sv
// Directed bench for phy_mgmt_ctrl with a behavioural PHY/serial-engine model
// answering on the management bus.
module tb_phy_mgmt_ctrl;

    localparam logic [4:0] PHYAD       = 5'd3;
    localparam int         POLL_GAP    = 4;
    localparam int         TXN_TIMEOUT = 20;
    localparam int         RST_POLLS   = 3;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic start = 1'b0;
    logic busy, linkUp, speed100, fullDuplex, error;

    int checks = 0;
    int passes = 0;

    logic        stuckReset = 1'b0;
    logic        stuckValid = 1'b0;
    logic [15:0] bmsrVal    = 16'h0024;
    logic [15:0] anlparVal  = 16'h41E1;

    int          phase     = 0;
    int          lat       = 0;
    int          txnCount  = 0;
    int          reg0Reads = 0;
    int          bmcrReads = 0;
    int          stabViol  = 0;
    int          wrCount   = 0;
    logic        latOp     = 1'b0;
    logic [4:0]  latPhyad  = '0;
    logic [4:0]  latRegad  = '0;
    logic [15:0] latWdata  = '0;
    logic [4:0]  wrReg  [0:31];
    logic [15:0] wrData [0:31];

    phy_mgmt_ctrl_if mdioBus();

    phy_mgmt_ctrl #(
        .PHYAD       (PHYAD),
        .POLL_GAP    (32'(POLL_GAP)),
        .TXN_TIMEOUT (32'(TXN_TIMEOUT)),
        .RST_POLLS   (RST_POLLS)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start),
        .mdio          (mdioBus),
        .busy_o        (busy),
        .link_up_o     (linkUp),
        .speed_100_o   (speed100),
        .full_duplex_o (fullDuplex),
        .error_o       (error)
    );

    always #5 clk = ~clk;

    // PHY model: drops valid on seeing mdio_en, answers a few cycles after en falls.
    always @(negedge clk) begin
        if (rst) begin
            phase = 0;
            mdioBus.mdio_valid = 1'b1;
            mdioBus.mdio_rdata = 16'h0000;
        end else if (stuckValid) begin
            mdioBus.mdio_valid = 1'b1;
        end else if (phase == 0) begin
            mdioBus.mdio_valid = 1'b1;
            mdioBus.mdio_rdata = 16'hFFFF;
            if (mdioBus.mdio_en) begin
                phase    = 1;
                lat      = 2;
                latOp    = mdioBus.mdio_op;
                latPhyad = mdioBus.mdio_phyad;
                latRegad = mdioBus.mdio_regad;
                latWdata = mdioBus.mdio_wdata;
                txnCount = txnCount + 1;
                mdioBus.mdio_valid = 1'b0;
            end
        end else begin
            if (mdioBus.mdio_op != latOp || mdioBus.mdio_phyad != latPhyad ||
                mdioBus.mdio_regad != latRegad || mdioBus.mdio_wdata != latWdata)
                stabViol = stabViol + 1;
            if (lat > 0) begin
                lat = lat - 1;
            end else if (!mdioBus.mdio_en) begin
                mdioBus.mdio_rdata = 16'h0000;
                if (latOp) begin
                    if (wrCount < 32) begin
                        wrReg[wrCount]  = latRegad;
                        wrData[wrCount] = latWdata;
                    end
                    wrCount = wrCount + 1;
                    if (latRegad == 5'd0 && latWdata[15]) bmcrReads = 0;
                end else begin
                    case (latRegad)
                        5'd0: begin
                            mdioBus.mdio_rdata = (stuckReset || bmcrReads == 0) ? 16'h8000 : 16'h0000;
                            bmcrReads = bmcrReads + 1;
                            reg0Reads = reg0Reads + 1;
                        end
                        5'd1:    mdioBus.mdio_rdata = bmsrVal;
                        5'd5:    mdioBus.mdio_rdata = anlparVal;
                        default: mdioBus.mdio_rdata = 16'h0000;
                    endcase
                end
                mdioBus.mdio_valid = 1'b1;
                phase = 0;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks = checks + 1;
        if (observed !== expected)
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        else
            passes = passes + 1;
    endtask

    task automatic applyStimulus(input logic rstVal, input logic startVal, input int cycles);
        rst   = rstVal;
        start = startVal;
        repeat (cycles) @(negedge clk);
    endtask

    function automatic logic condMet(input int sel);
        case (sel)
            0:       return linkUp;
            1:       return error;
            2:       return !linkUp;
            default: return mdioBus.mdio_en;
        endcase
    endfunction

    task automatic waitForCond(input int sel, input int budget, output int cycles);
        cycles = 0;
        while (!condMet(sel) && cycles < budget) begin
            @(negedge clk);
            cycles = cycles + 1;
        end
        checkOutput($sformatf("wait_sel%0d", sel), 32'(condMet(sel)), 32'd1);
    endtask

    initial begin
        int cyc;
        int baseTxn;
        int baseWr;
        int baseR0;

        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 3);
        checkOutput("rst_en",    32'(mdioBus.mdio_en), 32'd0);
        checkOutput("rst_bus",   32'({mdioBus.mdio_op, mdioBus.mdio_phyad, mdioBus.mdio_regad, mdioBus.mdio_wdata}), 32'd0);
        checkOutput("rst_flags", 32'({busy, linkUp, speed100, fullDuplex, error}), 32'd0);
        applyStimulus(1'b0, 1'b0, 3);
        checkOutput("idle_busy", 32'(busy), 32'd0);

        // Full bring-up: 100FD partner, reset bit clears on the second poll.
        baseTxn = txnCount; baseWr = wrCount; baseR0 = reg0Reads;
        applyStimulus(1'b0, 1'b1, 1);
        applyStimulus(1'b0, 1'b0, 1);
        checkOutput("start_busy", 32'(busy), 32'd1);
        waitForCond(0, 600, cyc);
        checkOutput("up_speed",   32'(speed100), 32'd1);
        checkOutput("up_duplex",  32'(fullDuplex), 32'd1);
        checkOutput("up_txns",    32'(txnCount - baseTxn), 32'd7);
        checkOutput("up_r0reads", 32'(reg0Reads - baseR0), 32'd2);
        checkOutput("up_writes",  32'(wrCount - baseWr), 32'd3);
        checkOutput("wr_bmcr_rst", 32'({wrReg[baseWr], wrData[baseWr]}), 32'({5'd0, 16'h8000}));
        checkOutput("wr_anar",     32'({wrReg[baseWr+1], wrData[baseWr+1]}), 32'({5'd4, 16'h01E1}));
        checkOutput("wr_bmcr_an",  32'({wrReg[baseWr+2], wrData[baseWr+2]}), 32'({5'd0, 16'h1200}));
        checkOutput("phyad", 32'(latPhyad), 32'(PHYAD));

        // Link stays up while BMSR reports link.
        baseTxn = txnCount;
        applyStimulus(1'b0, 1'b0, 40);
        checkOutput("mon_link", 32'(linkUp), 32'd1);
        checkOutput("mon_polls", 32'((txnCount - baseTxn) >= 2), 32'd1);
        checkOutput("mon_regad", 32'({latOp, latRegad}), 32'({1'b0, 5'd1}));

        // Link loss in MONITOR returns to LINK_POLL.
        bmsrVal = 16'h0020;
        waitForCond(2, 200, cyc);
        checkOutput("down_mode", 32'({speed100, fullDuplex}), 32'd0);
        checkOutput("down_busy", 32'(busy), 32'd1);
        baseTxn = txnCount;
        applyStimulus(1'b0, 1'b0, 40);
        checkOutput("lp_polls", 32'((txnCount - baseTxn) >= 2), 32'd1);
        checkOutput("lp_regad", 32'({latOp, latRegad}), 32'({1'b0, 5'd1}));
        checkOutput("lp_link",  32'(linkUp), 32'd0);

        // Relink with a 10FD-only partner.
        anlparVal = 16'h0061;
        bmsrVal   = 16'h0024;
        waitForCond(0, 200, cyc);
        checkOutput("10fd_speed",  32'(speed100), 32'd0);
        checkOutput("10fd_duplex", 32'(fullDuplex), 32'd1);

        // Reset during a transaction, with start asserted on the same cycle.
        waitForCond(3, 200, cyc);
        applyStimulus(1'b1, 1'b1, 1);
        checkOutput("midrst_en",    32'(mdioBus.mdio_en), 32'd0);
        checkOutput("midrst_bus",   32'({mdioBus.mdio_op, mdioBus.mdio_phyad, mdioBus.mdio_regad, mdioBus.mdio_wdata}), 32'd0);
        checkOutput("midrst_flags", 32'({busy, linkUp, speed100, fullDuplex, error}), 32'd0);
        applyStimulus(1'b0, 1'b0, 2);
        checkOutput("midrst_idle", 32'(busy), 32'd0);
        anlparVal = 16'h41E1;
        baseTxn = txnCount;
        applyStimulus(1'b0, 1'b1, 1);
        applyStimulus(1'b0, 1'b0, 1);
        waitForCond(0, 600, cyc);
        checkOutput("re_mode", 32'({speed100, fullDuplex}), 32'b11);
        checkOutput("re_txns", 32'(txnCount - baseTxn), 32'd7);

        // Reset bit never clears: FAULT after RST_POLLS reads.
        stuckReset = 1'b1;
        applyStimulus(1'b1, 1'b0, 2);
        applyStimulus(1'b0, 1'b0, 1);
        baseR0 = reg0Reads;
        applyStimulus(1'b0, 1'b1, 1);
        applyStimulus(1'b0, 1'b0, 1);
        waitForCond(1, 800, cyc);
        checkOutput("stuck_reads", 32'(reg0Reads - baseR0), 32'(RST_POLLS));
        checkOutput("stuck_flags", 32'({busy, linkUp, mdioBus.mdio_en}), 32'd0);
        applyStimulus(1'b0, 1'b1, 5);
        applyStimulus(1'b0, 1'b0, 5);
        checkOutput("fault_hold", 32'({error, busy, mdioBus.mdio_en}), 32'b100);

        // Engine never drops valid: timeout exactly TXN_TIMEOUT cycles after en rise.
        stuckReset = 1'b0;
        stuckValid = 1'b1;
        applyStimulus(1'b1, 1'b0, 2);
        applyStimulus(1'b0, 1'b1, 1);
        applyStimulus(1'b0, 1'b0, 0);
        waitForCond(3, 50, cyc);
        waitForCond(1, 100, cyc);
        checkOutput("to_cycles", 32'(cyc), 32'(TXN_TIMEOUT));
        checkOutput("to_flags",  32'({mdioBus.mdio_en, busy}), 32'd0);
        stuckValid = 1'b0;
        applyStimulus(1'b1, 1'b0, 2);

        checkOutput("bus_stable", 32'(stabViol), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
